// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Build option IMEM_CHECKSUM_EN adds the CHK/ERR states.
package imem_pkg;

  localparam int         ADDR_W_DEF     = 8;
  localparam int         DATA_W_DEF     = 8;
  localparam logic [7:0] NOP_INST       = 8'h00;
  localparam int         LEN_ZERO_MEANS = 256;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    RUN
`ifdef IMEM_CHECKSUM_EN
    , CHK,
    ERR
`endif
  } state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory, then enables the CPU.
// Define IMEM_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [DATA_W-1:0] inst,
  output logic              cpu_enable,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = ADDR_W + 1;

  state_e              state;
  logic [CNT_W-1:0]    rem;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]   rd_data;
  logic                xfer;
  logic                we;

  assign xfer = ld_valid && ld_ready;
  // A restart pulse wins over a byte offered in the same cycle.
  assign we   = xfer && (state == LOAD) && !load_start;

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  logic              err_q;
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rem        <= '0;
      wr_ptr     <= '0;
      ld_ready   <= 1'b0;
      cpu_enable <= 1'b0;
      load_done  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum       <= '0;
      err_q      <= 1'b0;
`endif
    end else if (load_start) begin
      state      <= LEN;
      rem        <= '0;
      wr_ptr     <= '0;
      ld_ready   <= 1'b1;
      cpu_enable <= 1'b0;
      load_done  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        LEN: if (xfer) begin
          // Length byte 0 encodes a full-memory load.
          rem    <= (ld_data == '0) ? CNT_W'(DEPTH) : CNT_W'(ld_data);
          wr_ptr <= '0;
          state  <= LOAD;
`ifdef IMEM_CHECKSUM_EN
          csum   <= ld_data;
`endif
        end
        LOAD: if (xfer) begin
          wr_ptr <= wr_ptr + 1'b1;
          rem    <= rem - 1'b1;
`ifdef IMEM_CHECKSUM_EN
          csum   <= csum ^ ld_data;
          if (rem == CNT_W'(1)) state <= CHK;
`else
          if (rem == CNT_W'(1)) begin
            state      <= RUN;
            ld_ready   <= 1'b0;
            cpu_enable <= 1'b1;
            load_done  <= 1'b1;
          end
`endif
        end
`ifdef IMEM_CHECKSUM_EN
        CHK: if (xfer) begin
          ld_ready <= 1'b0;
          if (ld_data == csum) begin
            state      <= RUN;
            cpu_enable <= 1'b1;
            load_done  <= 1'b1;
          end else begin
            state <= ERR;
            err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(ld_data),
    .raddr(pc_addr),
    .rdata(rd_data)
  );

  assign inst = (state == RUN) ? rd_data : DATA_W'(NOP_INST);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream model.
module tb_imem_loader;

`ifdef IMEM_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic [7:0] pc_addr = 8'h00;
  logic       ld_ready, cpu_enable, load_done, load_err;
  logic [7:0] inst;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] cs;

  imem_loader dut (
    .clk       (clk),
    .reset     (rst_n),
    .load_start(load_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .pc_addr   (pc_addr),
    .inst      (inst),
    .cpu_enable(cpu_enable),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Model: the list of bytes accepted since the last load_start decides everything.
  bit         started;
  int         mlen;
  logic [7:0] mq [0:257];
  logic [7:0] mem_m [256];
  bit         known [256];

  function automatic int n_len();
    return (mq[0] == 8'h00) ? 256 : int'(mq[0]);
  endfunction

  function automatic bit m_done();
    return started && mlen > 0 && mlen == 1 + n_len() + CK;
  endfunction

  function automatic bit m_ready();
    return started && !m_done();
  endfunction

  function automatic bit m_ok();
    logic [7:0] x = 8'h00;
    if (CK == 0) return 1'b1;
    for (int i = 0; i < mlen - 1; i++) x ^= mq[i];
    return x == mq[mlen-1];
  endfunction

  function automatic bit m_run();
    return m_done() && m_ok();
  endfunction

  function automatic bit m_err();
    return m_done() && !m_ok();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      mlen    <= 0;
    end else if (load_start) begin
      started <= 1'b1;
      mlen    <= 0;
    end else if (ld_valid && m_ready()) begin
      mq[mlen] <= ld_data;
      mlen     <= mlen + 1;
      if (mlen >= 1 && mlen <= n_len()) begin
        mem_m[mlen-1] <= ld_data;
        known[mlen-1] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%02h want=%02h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp();
    chk("ld_ready", 8'(ld_ready), 8'(m_ready()));
    chk("cpu_enable", 8'(cpu_enable), 8'(m_run()));
    chk("load_done", 8'(load_done), 8'(m_run()));
    chk("load_err", 8'(load_err), 8'(m_err()));
    if (m_run()) begin
      if (known[pc_addr]) chk("inst", inst, mem_m[pc_addr]);
    end else begin
      chk("inst_nop", inst, 8'h00);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    cmp();
  endtask

  task automatic start();
    load_start = 1'b1;
    cs = 8'h00;
    tick();
    load_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit gappy);
    bit acc = 1'b0;
    bit ph = 1'b0;
    int n = 0;
    load_start = 1'b0;
    cs ^= b;
    do begin
      ld_valid = gappy ? ph : 1'b1;
      ph = ~ph;
      ld_data = ld_valid ? b : 8'($urandom);
      acc = ld_valid && m_ready();
      tick();
      n++;
    end while (!acc && n < 40);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL byte_accept cyc=%0d got=not_taken want=taken byte=%02h", cyc, b);
    end
  endtask

  task automatic finish_load(input bit good);
    logic [7:0] c;
    c = good ? cs : (cs ^ 8'h01);
    if (CK != 0) drive_byte(c, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      load_start = 1'b0;
      pc_addr  = 8'($urandom);
      ld_valid = 1'($urandom);
      ld_data  = 8'($urandom);
      tick();
    end
  endtask

  task automatic quiet();
    ld_valid = 1'b0;
    load_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle behaviour
    tick(); tick();
    rst_n = 1'b1;
    idle(8);
    quiet();
    pc_addr = 8'h37;
    tick();
    chk("lit_idle_cpu_en", 8'(cpu_enable), 8'h00);
    chk("lit_idle_inst", inst, 8'h00);

    // Short back-to-back load
    start();
    drive_byte(8'h03, 1'b0);
    drive_byte(8'hA1, 1'b0);
    drive_byte(8'hB2, 1'b0);
    drive_byte(8'hC3, 1'b0);
    finish_load(1'b1);
    quiet();
    pc_addr = 8'h00; tick(); chk("lit_run_pc0", inst, 8'hA1);
    pc_addr = 8'h01; tick(); chk("lit_run_pc1", inst, 8'hB2);
    pc_addr = 8'h02; tick(); chk("lit_run_pc2", inst, 8'hC3);
    chk("lit_run_cpu_en", 8'(cpu_enable), 8'h01);
    chk("model_mem2", mem_m[2], 8'hC3);

    // Full 256-byte load with ld_valid toggling
    start();
    drive_byte(8'h00, 1'b1);
    for (int a = 0; a < 256; a++) drive_byte(8'(a), 1'b1);
    finish_load(1'b1);
    quiet();
    pc_addr = 8'hFF; tick(); chk("lit_full_pcff", inst, 8'hFF);
    pc_addr = 8'h00; tick(); chk("lit_full_pc00", inst, 8'h00);
    chk("model_mem255", mem_m[255], 8'hFF);
    idle(20);

    // Restart mid-load; byte offered alongside the restart is dropped
    start();
    drive_byte(8'h05, 1'b0);
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h66, 1'b0);
    ld_valid = 1'b1; ld_data = 8'hEE; load_start = 1'b1; cs = 8'h00;
    tick();
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h7E, 1'b0);
    finish_load(1'b1);
    quiet();
    pc_addr = 8'h00; tick(); chk("lit_restart_pc0", inst, 8'h7E);
    pc_addr = 8'h01; tick(); chk("lit_restart_pc1", inst, 8'h66);
    pc_addr = 8'h02; tick(); chk("lit_restart_pc2", inst, 8'h02);
    chk("lit_restart_done", 8'(load_done), 8'h01);

    // Asynchronous reset in the middle of a load
    start();
    drive_byte(8'h04, 1'b0);
    drive_byte(8'h10, 1'b0);
    drive_byte(8'h20, 1'b0);
    ld_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_ready", 8'(ld_ready), 8'h00);
    chk("lit_arst_cpu_en", 8'(cpu_enable), 8'h00);
    chk("lit_arst_done", 8'(load_done), 8'h00);
    chk("lit_arst_err", 8'(load_err), 8'h00);
    chk("lit_arst_inst", inst, 8'h00);
    tick();
    rst_n = 1'b1;
    idle(4);
    chk("lit_post_rst_done", 8'(load_done), 8'h00);

`ifdef IMEM_CHECKSUM_EN
    start();
    drive_byte(8'h02, 1'b0); drive_byte(8'h11, 1'b0); drive_byte(8'h22, 1'b0);
    drive_byte(8'h31, 1'b0);
    quiet(); tick(); tick();
    chk("lit_ck_good_cpu_en", 8'(cpu_enable), 8'h01);
    chk("lit_ck_good_err", 8'(load_err), 8'h00);
    start();
    drive_byte(8'h02, 1'b0); drive_byte(8'h11, 1'b0); drive_byte(8'h22, 1'b0);
    drive_byte(8'h30, 1'b0);
    idle(3);
    chk("lit_ck_bad_err", 8'(load_err), 8'h01);
    chk("lit_ck_bad_cpu_en", 8'(cpu_enable), 8'h00);
    start();
    chk("lit_ck_clear_err", 8'(load_err), 8'h00);
`endif

    // Random loads, gaps, aborts and checksum outcomes
    for (int it = 0; it < 30; it++) begin
      int  len;
      int  nsend;
      bit  abort;
      bit  gap;
      len   = $urandom_range(1, 12);
      abort = ($urandom_range(0, 4) == 0);
      gap   = 1'($urandom);
      nsend = abort ? $urandom_range(0, len - 1) : len;
      start();
      drive_byte(8'(len), gap);
      for (int k = 0; k < nsend; k++) drive_byte(8'($urandom), gap);
      if (!abort) finish_load($urandom_range(0, 3) != 0);
      quiet();
      idle(6);
    end

    quiet();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction memory depth in bytes; fixed to 2**ADDR_W.
REQ-002 Parameter: ADDR_W, 8, fetch/write address width.
REQ-003 Parameter: DATA_W, 8, instruction and load byte width.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset (asserts immediately; deassertion is synchronous to clk).
REQ-006 Port: load_start  in  1  one-cycle pulse that begins a program load.
REQ-007 Port: ld_valid  in  1  load byte present on ld_data.
REQ-008 Port: ld_data  in  8  load stream byte.
REQ-009 Port: ld_ready  out  1  loader accepts ld_data this cycle.
REQ-010 Port: pc_addr  in  8  fetch address from datapath PC.
REQ-011 Port: inst  out  8  instruction at pc_addr.
REQ-012 Port: cpu_enable  out  1  datapath run enable.
REQ-013 Port: load_done  out  1  high while a valid program is resident.
REQ-014 Port: load_err  out  1  sticky checksum error flag (constant 0 without IMEM_CHECKSUM_EN).

Function
REQ-015 FSM states: IDLE, LEN, LOAD, CHK, RUN, ERR; CHK and ERR exist only with IMEM_CHECKSUM_EN.
REQ-016 Byte transfer occurs on a rising edge where ld_valid and ld_ready are both 1; ld_ready = 1 only in LEN, LOAD, CHK.
REQ-017 IDLE -> LEN on load_start; LEN captures first accepted byte as count N, N = 0 meaning 256, -> LOAD.
REQ-018 LOAD writes byte k (k = 0..N-1) to memory address k; 9-bit remaining counter decrements per transfer.
REQ-019 On the transfer of byte N-1: -> RUN (no checksum) or -> CHK (checksum).
REQ-020 RUN: cpu_enable = 1 and load_done = 1 from the first cycle after entry; ld_ready = 0.
REQ-021 inst is a combinational read of mem[pc_addr] in RUN; inst = 8'h00 (NOP) in every other state.
REQ-022 Addresses >= N keep their previous contents; no memory clear on load.
REQ-023 load_start in any state other than IDLE restarts at LEN with cpu_enable = 0, load_done = 0 next cycle; an ld transfer in the same cycle is discarded.
REQ-024 ld_valid without ld_ready is ignored; ld_valid may be deasserted mid-load with no effect on state.
REQ-025 Write address never wraps within a load: N = 256 writes 0x00..0xFF exactly once.

Reset
REQ-026 reset low: state = IDLE, counters = 0, cpu_enable = 0, load_done = 0, load_err = 0, ld_ready = 0, inst = 8'h00.
REQ-027 Memory array contents are not reset; reset mid-load abandons the load and load_done stays 0 until a complete reload.

Configuration
REQ-028 Macro IMEM_CHECKSUM_EN defined: after byte N-1, state CHK accepts one checksum byte; compared with XOR of N and all N data bytes.
REQ-029 Match -> RUN; mismatch -> ERR with load_err = 1, cpu_enable = 0, load_done = 0; ERR exits only via load_start (clears load_err) or reset.
REQ-030 Macro IMEM_CHECKSUM_EN undefined: no CHK/ERR states, load_err tied to 0, LOAD goes directly to RUN.

Structure
REQ-031 Shared package imem_pkg: FSM state enum, ADDR_W/DATA_W defaults, NOP_INST = 8'h00, LEN_ZERO_MEANS = 256.
REQ-032 One sub-module imem_ram: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.

Verification
REQ-033 reset low, release, no load_start -> cpu_enable = 0, inst = 00 for any pc_addr.
REQ-034 load_start; stream 03, A1, B2, C3 back-to-back -> RUN one cycle after C3 accepted; pc_addr 0/1/2 -> A1/B2/C3; cpu_enable = 1.
REQ-035 Stream 00 then 256 bytes (value = address), ld_valid toggled every other cycle -> exactly 256 writes; pc_addr FF -> FF; no wrap overwrite of address 0.
REQ-036 load_start after 2 of 5 data bytes, then 01, 7E -> pc_addr 0 -> 7E, pc_addr 1 keeps prior contents, load_done = 1.
REQ-037 reset pulsed low mid-load -> all outputs at reset values within the same cycle; load_done = 0 after release.
REQ-038 With IMEM_CHECKSUM_EN: 02, 11, 22, checksum 31 -> RUN; checksum 30 -> ERR, load_err = 1, cpu_enable = 0 until load_start.
